vram_arbiter: RTL

//  Shares the single-port 4Kx8 video RAM between the MC6847-style display fetch port and the CPU.

---
 rtl/vram_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port video RAM between the display
// fetch port and the CPU, and holds the vblank-synchronised mode reg.
//
// Ports:
//   clk_25, reset_n           clock, async active-low reset
//   vid_req/vid_addr          display fetch strobe + address
//   vid_data/vid_valid        fetched byte + 1-cycle valid pulse
//   vid_overrun/vid_ovr_clr   sticky overrun flag + clear
//   cpu_req/we/addr/wdata     CPU request (held until cpu_ack)
//   cpu_rdata/cpu_ack         CPU read data + completion pulse
//   vblank                    vertical blank level
//   ram_addr/we/wdata/rdata   synchronous RAM port
//   mode_ag/sa/inv            live display mode bits
module vram_arbiter #(
  parameter int         ADDR_W     = 12,
  parameter int         DATA_W     = 8,
  parameter logic [2:0] MODE_RESET = 3'b000
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              vid_ovr_clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vblank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              mode_ag,
  output logic              mode_sa,
  output logic              mode_inv
);

  typedef enum logic [2:0] {
    IDLE,
    V_ADDR,
    V_DATA,
    C_ADDR,
    C_DATA,
    C_REG
  } state_t;

  state_t            state_q, state_d;
  logic              vid_pend_q;
  logic [ADDR_W-1:0] vaddr_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              vid_valid_q;
  logic              ovr_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ack_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [2:0]        shadow_q, shadow_d;
  logic [2:0]        live_q;
  logic              vblank_q;

  logic              pend_w;
  logic              cpu_go;
  logic [ADDR_W-1:0] vaddr_w;
  state_t            cpu_tgt;

  // A strobe in the current cycle counts as pending so an idle
  // fetch starts at once; the newest address always wins.
  assign pend_w  = vid_pend_q | vid_req;
  assign vaddr_w = vid_req ? vid_addr : vaddr_q;
  // While cpu_ack is high the held request is the one just served.
  assign cpu_go  = cpu_req & ~cpu_ack_q;
  assign cpu_tgt = cpu_addr[ADDR_W] ? C_REG : C_ADDR;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pend_w)      state_d = V_ADDR;
        else if (cpu_go) state_d = cpu_tgt;
      end
      V_ADDR: state_d = V_DATA;
      V_DATA: begin
        if (cpu_go)      state_d = cpu_tgt;
        else if (pend_w) state_d = V_ADDR;
        else             state_d = IDLE;
      end
      C_ADDR: state_d = C_DATA;
      C_DATA,
      C_REG: state_d = pend_w ? V_ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (state_q == C_REG && cpu_we)
      shadow_d = cpu_wdata[2:0];
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vid_pend_q  <= 1'b0;
      vaddr_q     <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      shadow_q    <= MODE_RESET;
      live_q      <= MODE_RESET;
      vblank_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      vblank_q    <= vblank;

      if (vid_req) begin
        vaddr_q    <= vid_addr;
        vid_pend_q <= 1'b1;
      end

      if (vid_req && (vid_pend_q || state_q == V_ADDR))
        ovr_q <= 1'b1;
      else if (vid_ovr_clr)
        ovr_q <= 1'b0;

      if (state_d == V_ADDR) begin
        ram_addr_q <= vaddr_w;
        vid_pend_q <= 1'b0;
      end

      if (state_d == C_ADDR) begin
        ram_addr_q  <= cpu_addr[ADDR_W-1:0];
        ram_we_q    <= cpu_we;
        ram_wdata_q <= cpu_wdata;
      end

      if (state_q == V_DATA) begin
        vid_data_q  <= ram_rdata;
        vid_valid_q <= 1'b1;
      end

      if (state_q == C_DATA) begin
        cpu_ack_q   <= 1'b1;
        cpu_rdata_q <= cpu_we ? '0 : ram_rdata;
      end

      if (state_q == C_REG) begin
        cpu_ack_q   <= 1'b1;
        cpu_rdata_q <= cpu_we ? '0 : {{(DATA_W-3){1'b0}}, shadow_q};
      end

      shadow_q <= shadow_d;
      // shadow_d lets a write in the rising-edge cycle go live too.
      if (vblank && !vblank_q)
        live_q <= shadow_d;
    end
  end

  assign vid_data    = vid_data_q;
  assign vid_valid   = vid_valid_q;
  assign vid_overrun = ovr_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign mode_ag     = live_q[2];
  assign mode_sa     = live_q[1];
  assign mode_inv    = live_q[0];

endmodule
